dtim_responder: RTL and testbench

//  Data tightly-integrated memory (DTIM): the responder end of the load/store unit's memory port.

---
 rtl/dtim_responder.sv | 136 +++++++++++++
 tb/tb_dtim_responder.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/dtim_responder.sv
// Data tightly-integrated memory responder for the LSU memory port.
// Single-cycle request accept, one-cycle registered response with a
// valid/error strobe, and a sequential zero-fill engine that runs after
// every reset before requests are accepted.
module dtim_responder #(
  parameter int unsigned DEPTH     = 1024,
  parameter logic [31:0] BASE_ADDR = 32'h0000_2000
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        Req,
  input  logic [31:0] Adr,
  input  logic [3:0]  WriteByteEn,
  input  logic [31:0] WD,
  output logic        Ready,
  output logic        RDValid,
  output logic [31:0] RD,
  output logic        Err
);

  localparam int unsigned   AW       = $clog2(DEPTH);
  localparam logic [31:0]   WinBytes = 32'(DEPTH * 4);
  localparam logic [AW-1:0] LastIdx  = AW'(DEPTH - 1);

  // Controller states: zero-fill first, then serve requests until reset.
  localparam logic [0:0] StInit = 1'b0;
  localparam logic [0:0] StRun  = 1'b1;

  logic [0:0]    state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;

  logic          rdvalid_q, rdvalid_d;
  logic [31:0]   rd_q, rd_d;
  logic          err_q, err_d;

  logic [31:0]   mem [DEPTH];

  logic [31:0]   offs;
  logic          in_range;
  logic [AW-1:0] idx;
  logic          accept;
  logic          is_read;
  logic          mem_we;

  // Address decode: offsets below the base wrap to large values and
  // therefore fall out of the window naturally.
  always_comb begin
    offs     = Adr - BASE_ADDR;
    in_range = (offs < WinBytes);
    idx      = offs[AW+1:2];
    accept   = Req & Ready;
    is_read  = (WriteByteEn == 4'b0000);
    mem_we   = accept & in_range & ~is_read;
  end

  // Ready depends only on the state register, so an async reset drops it at once.
  assign Ready = (state_q == StRun);

  // Next-state for the init engine and controller FSM.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StInit: begin
        cnt_d = cnt_q + AW'(1);
        if (cnt_q == LastIdx) begin
          state_d = StRun;
          cnt_d   = '0;
        end
      end
      StRun: begin
        state_d = StRun;
      end
      default: begin
        state_d = StInit;
        cnt_d   = '0;
      end
    endcase
  end

  // Controller state registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= StInit;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Storage array: zero-filled word by word during init, byte-masked writes in run.
  always_ff @(posedge clk) begin
    if (state_q == StInit) begin
      mem[cnt_q] <= '0;
    end else if (mem_we) begin
      for (int i = 0; i < 4; i++) begin
        if (WriteByteEn[i]) begin
          mem[idx][8*i +: 8] <= WD[8*i +: 8];
        end
      end
    end
  end

  // Response next-state: RD carries data only for in-window reads, zero otherwise.
  always_comb begin
    rdvalid_d = accept;
    rd_d      = '0;
    err_d     = 1'b0;
    if (accept) begin
      if (!in_range) begin
        err_d = 1'b1;
      end else if (is_read) begin
        rd_d = mem[idx];
      end
    end
  end

  // Response registers; reset discards any in-flight response.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rdvalid_q <= 1'b0;
      rd_q      <= '0;
      err_q     <= 1'b0;
    end else begin
      rdvalid_q <= rdvalid_d;
      rd_q      <= rd_d;
      err_q     <= err_d;
    end
  end

  assign RDValid = rdvalid_q;
  assign RD      = rd_q;
  assign Err     = err_q;

endmodule

// File: tb/tb_dtim_responder.sv
// Self-checking bench for dtim_responder: behavioural memory model with a
// per-cycle compare process, plus directed literal checks.
module tb_dtim_responder;

  localparam int unsigned DEPTH = 64;
  localparam logic [31:0] BASE  = 32'h0000_2000;
  localparam logic [31:0] WIN   = 32'(DEPTH * 4);

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        Req = 1'b0;
  logic [31:0] Adr = '0;
  logic [3:0]  WriteByteEn = '0;
  logic [31:0] WD = '0;
  logic        Ready;
  logic        RDValid;
  logic [31:0] RD;
  logic        Err;

  always #5 clk = ~clk;

  dtim_responder #(
    .DEPTH    (DEPTH),
    .BASE_ADDR(BASE)
  ) dut (
    .clk        (clk),
    .resetn     (resetn),
    .Req        (Req),
    .Adr        (Adr),
    .WriteByteEn(WriteByteEn),
    .WD         (WD),
    .Ready      (Ready),
    .RDValid    (RDValid),
    .RD         (RD),
    .Err        (Err)
  );

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, want %h (t=%0t)", name, act, exp, $time);
  endtask

  // Behavioural model: edges counted since reset release; the array reads
  // as all-zero after any reset; one response per accepted request.
  logic [31:0] m_mem [DEPTH];
  int unsigned edges;
  logic        e_v;
  logic        e_err;
  logic [31:0] e_rd;
  logic [31:0] m_offs;
  logic        m_acc;

  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      edges = 0;
      for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
      e_v   = 1'b0;
      e_err = 1'b0;
      e_rd  = '0;
    end else begin
      m_acc = Req && (edges >= DEPTH);
      e_v   = m_acc;
      e_err = 1'b0;
      e_rd  = '0;
      if (m_acc) begin
        m_offs = Adr - BASE;
        if (m_offs >= WIN) begin
          e_err = 1'b1;
        end else if (WriteByteEn == 4'b0000) begin
          e_rd = m_mem[m_offs / 4];
        end else begin
          for (int l = 0; l < 4; l++)
            if (WriteByteEn[l]) m_mem[m_offs / 4][8*l +: 8] = WD[8*l +: 8];
        end
      end
      if (edges < DEPTH + 4) edges = edges + 1;
    end
  end

  // Compare process: every cycle, away from the active edge.
  always @(negedge clk) begin
    check("ready",   32'(Ready),   32'(resetn && (edges >= DEPTH)));
    check("rdvalid", 32'(RDValid), 32'(e_v));
    check("rd",      RD,           e_rd);
    check("err",     32'(Err),     32'(e_err));
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic rq, input logic [31:0] a, input logic [3:0] be,
                       input logic [31:0] d);
    Req         = rq;
    Adr         = a;
    WriteByteEn = be;
    WD          = d;
  endtask

  task automatic check_resp(input string name, input logic v, input logic [31:0] d,
                            input logic e);
    check({name, "_valid"}, 32'(RDValid), 32'(v));
    check({name, "_rd"},    RD,           d);
    check({name, "_err"},   32'(Err),     32'(e));
  endtask

  int  zeros;
  logic saw_valid;
  int  r;

  initial begin
    repeat (3) @(posedge clk);
    #1;

    // Init: Req held high while zero-fill runs
    drive(1'b1, BASE + 32'h10, 4'b0000, '0);
    resetn    = 1'b1;
    zeros     = 0;
    saw_valid = 1'b0;
    for (int k = 0; k < DEPTH + 8 && !Ready; k++) begin
      if (RDValid) saw_valid = 1'b1;
      zeros++;
      step();
    end
    check("init_ready_delay", 32'(zeros), 32'(DEPTH));
    check("init_no_rdvalid", 32'(saw_valid), 32'(0));
    check("init_ready_up", 32'(Ready), 32'(1));
    step();
    check_resp("init_read", 1'b1, 32'h0, 1'b0);

    // Full write then immediate read of the same word
    drive(1'b1, BASE + 32'h4, 4'b1111, 32'hDEAD_BEEF);
    step();
    check_resp("wr_full", 1'b1, 32'h0, 1'b0);
    drive(1'b1, BASE + 32'h4, 4'b0000, '0);
    step();
    check_resp("rd_after_wr", 1'b1, 32'hDEAD_BEEF, 1'b0);
    drive(1'b0, '0, 4'b0000, '0);
    step();
    check("idle_no_valid", 32'(RDValid), 32'(0));

    // Single-lane write, Adr low bits ignored
    drive(1'b1, BASE + 32'h4, 4'b1111, 32'h1122_3344);
    step();
    drive(1'b1, BASE + 32'h6, 4'b0100, 32'h5555_5555);
    step();
    drive(1'b1, BASE + 32'h4, 4'b0000, '0);
    step();
    check_resp("lane_merge", 1'b1, 32'h1155_3344, 1'b0);

    // Window boundaries
    drive(1'b1, BASE + WIN, 4'b0000, '0);
    step();
    check_resp("oor_high_rd", 1'b1, 32'h0, 1'b1);
    drive(1'b1, BASE - 32'h4, 4'b1111, 32'hFFFF_FFFF);
    step();
    check_resp("oor_low_wr", 1'b1, 32'h0, 1'b1);
    drive(1'b1, BASE, 4'b0000, '0);
    step();
    check_resp("word0_intact", 1'b1, 32'h0, 1'b0);
    drive(1'b1, BASE + WIN - 32'h1, 4'b0000, '0);
    step();
    check_resp("last_word_intact", 1'b1, 32'h0, 1'b0);

    // Random back-to-back traffic against the model
    for (int i = 0; i < 100; i++) begin
      r = int'($urandom_range(0, 9));
      Req = 1'b1;
      if (r == 0)      Adr = BASE + WIN + $urandom_range(0, 255);
      else if (r == 1) Adr = BASE - 32'h1 - $urandom_range(0, 255);
      else if (r < 6)  Adr = BASE + $urandom_range(0, 31);
      else             Adr = BASE + $urandom_range(0, WIN - 1);
      WriteByteEn = ($urandom_range(0, 2) == 0) ? 4'b0000 : 4'($urandom_range(0, 15));
      WD = $urandom;
      step();
      check("rand_valid", 32'(RDValid), 32'(1));
    end

    // Async reset mid-stream
    drive(1'b1, BASE + 32'h4, 4'b1111, 32'hCAFE_F00D);
    step();
    drive(1'b1, BASE + 32'h4, 4'b0000, '0);
    @(posedge clk);
    #3;
    resetn = 1'b0;
    #1;
    check("rst_ready",   32'(Ready),   32'(0));
    check("rst_rdvalid", 32'(RDValid), 32'(0));
    check("rst_rd",      RD,           32'h0);
    check("rst_err",     32'(Err),     32'(0));
    drive(1'b0, '0, 4'b0000, '0);
    repeat (2) @(posedge clk);
    #1;
    resetn = 1'b1;
    for (int k = 0; k < DEPTH + 8 && !Ready; k++) step();
    check("rerun_ready", 32'(Ready), 32'(1));
    drive(1'b1, BASE + 32'h4, 4'b0000, '0);
    step();
    check_resp("cleared_after_rst", 1'b1, 32'h0, 1'b0);
    drive(1'b0, '0, 4'b0000, '0);
    step();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
